mem_ctrl_rw_sched: RTL and testbench
====================================

Name: mem_ctrl_rw_sched

Overview:
Read/write command scheduler between the AXI slave front-end and the LPDDR5 command queue. It buffers read and write commands in separate per-direction FIFOs and issues them to the command queue one at a time. Reads have priority. Writes are batched into drain bursts controlled by watermarks and an aging timer. A bus-turnaround gap of idle cycles is inserted on every direction change.

Parameters:
ID_WIDTH, 8, command ID width
ADDR_WIDTH, 40, command address width
FIFO_DEPTH, 8, entries per direction FIFO (power of 2, >=4)
WR_HI_WM, 6, write count that forces a write drain
WR_LO_WM, 2, write count at or below which a drain may end
WR_MAX_WAIT, 64, cycles a pending write may wait in read mode
MAX_WR_RUN, 16, max consecutive writes while reads are pending
TURN_CYCLES, 4, idle cycles per direction switch (>=1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
rd_req_valid_i  in  1  read command valid
rd_req_ready_o  out  1  read command accepted (= !rd_full)
rd_req_cmd_i  in  CMD_W  read command
wr_req_valid_i  in  1  write command valid
wr_req_ready_o  out  1  write command accepted (= !wr_full)
wr_req_cmd_i  in  CMD_W  write command
cmd_valid_o  out  1  scheduled command valid (registered)
cmd_data_o  out  CMD_W  scheduled command (registered)
cmd_ready_i  in  1  command queue can accept (= !full)
rd_count_o  out  clog2(FIFO_DEPTH)+1  read FIFO occupancy
wr_count_o  out  clog2(FIFO_DEPTH)+1  write FIFO occupancy
status_o  out  8  {state[1:0], rd_full, wr_full, rd_empty, wr_empty, cmd_valid_o, 1'b0}

Behaviour:
- Reset: clock clk_i; reset rst_n_i, asynchronous, active-low. While asserted: FIFOs empty, state S_READ, cmd_valid_o=0, cmd_data_o=0, counters=0, rd/wr_req_ready_o=1, counts=0. Reset mid-operation discards all buffered commands.
- Command format: CMD_W = ID_WIDTH+ADDR_WIDTH+10, laid out as {id, addr, is_write[9], len[8:5], size[4:2], burst[1:0]}.
- On issue, the scheduler forces bit 9 to the direction of the source FIFO; the incoming bit 9 is ignored.
- Push: a command is pushed on valid&&ready. Ready is !full only, so there is no push into a full FIFO even if a pop occurs in the same cycle. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Issue slot: a slot exists when !cmd_valid_o || cmd_ready_i. On an issue, the FIFO head is popped and loaded into the output register.
- cmd_valid_o and cmd_data_o are held stable while cmd_valid_o && !cmd_ready_i.
- Latency: a command pushed in cycle N with an idle scheduler in the matching mode gives cmd_valid_o=1 in cycle N+2.
- State machine: S_READ, S_WRITE, S_TURN_R2W, S_TURN_W2R. A switch is decided before issue; in a switching cycle nothing is issued.
- S_READ:
  - Switch to S_TURN_R2W if wr_count>=WR_HI_WM, or (rd_empty && !wr_empty), or wr_wait==WR_MAX_WAIT.
  - Otherwise issue a read if !rd_empty and a slot exists.
- S_WRITE:
  - Switch to S_TURN_W2R if !rd_empty and any of: wr_empty, wr_count<=WR_LO_WM, or wr_run==MAX_WR_RUN.
  - Otherwise issue a write if !wr_empty and a slot exists.
  - If both FIFOs are empty, stay in S_WRITE.
- S_TURN_*: turn_cnt counts TURN_CYCLES cycles with no issue, then moves to the target mode. The output register may still drain during the turn.
- wr_wait: 8-bit saturating counter. It increments each cycle in S_READ with !wr_empty and clears otherwise. The comparison is against WR_MAX_WAIT.
- wr_run: increments per write issued, clears on entering S_WRITE, saturates at MAX_WR_RUN.
- Widths: all counters saturate and never wrap. FIFO pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty.

Decomposition:
- Package mem_ctrl_pkg holds:
  - CMD_W and the field offsets (CMD_WR_BIT=9, LEN_LSB=5, SIZE_LSB=2, BURST_LSB=0).
  - Enum sched_state_e.
  - Default watermark constants.
- Sub-module mem_ctrl_cmd_fifo: synchronous FIFO with count, full and empty outputs; instantiated twice.

Test Plan:
- Single read: push rd cmd id=0x11 addr=0x1000 in cycle N -> cmd_valid_o=1 in N+2, cmd_data_o bit9=0, state remains S_READ.
- Lone write: push 1 write in cycle N with rd empty -> S_TURN_R2W for 4 cycles, cmd_valid_o=1 at N+7, bit9=1.
- Watermark drain: continuous reads plus 6 writes pushed -> switch at wr_count=6, exactly 4 writes issued, 4-cycle turn, reads resume.
- Aging: 1 write pending under continuous reads -> switch to S_TURN_R2W after 64 cycles in S_READ.
- Backpressure: cmd_ready_i=0 for 20 cycles while pushing 10 reads -> output stable, rd_req_ready_o=0 at count 8, no loss or reorder after release.
- Reset mid-drain with 5 writes buffered -> all outputs at reset values the same cycle; post-reset output contains no stale commands.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the LPDDR5 read/write command scheduler:
//   - command word width and field offsets
//     {id, addr, is_write[9], len[8:5], size[4:2], burst[1:0]}
//   - scheduler state encoding (also reported in status_o[7:6])
//   - default parameter values for the scheduler
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int ID_WIDTH_DEF    = 8;
    localparam int ADDR_WIDTH_DEF  = 40;
    localparam int CMD_W           = ID_WIDTH_DEF + ADDR_WIDTH_DEF + 10;

    localparam int CMD_WR_BIT      = 9;
    localparam int LEN_LSB         = 5;
    localparam int SIZE_LSB        = 2;
    localparam int BURST_LSB       = 0;

    localparam int FIFO_DEPTH_DEF  = 8;
    localparam int WR_HI_WM_DEF    = 6;
    localparam int WR_LO_WM_DEF    = 2;
    localparam int WR_MAX_WAIT_DEF = 64;
    localparam int MAX_WR_RUN_DEF  = 16;
    localparam int TURN_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        S_READ     = 2'd0,
        S_WRITE    = 2'd1,
        S_TURN_R2W = 2'd2,
        S_TURN_W2R = 2'd3
    } sched_state_e;

endpackage

// File: rtl/mem_ctrl_cmd_fifo.sv
// -----------------------------------------------------------------------------
// mem_ctrl_cmd_fifo
// Synchronous first-word-fall-through command FIFO with occupancy count.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   i_push, i_data   write side; a push into a full FIFO is ignored
//   i_pop            read side; a pop of an empty FIFO is ignored
//   o_data           current head entry (valid when !o_empty)
//   o_count          occupancy, 0..DEPTH
//   o_full, o_empty  status flags
// -----------------------------------------------------------------------------
module mem_ctrl_cmd_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 58,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra MSB: equal pointers mean empty, pointers that
    // differ only in the MSB mean full. Their difference is the occupancy.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // NOTE: storage is deliberately left out of reset; the pointers alone
    // decide which entries are live, and an unreset array maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/mem_ctrl_rw_sched.sv
// -----------------------------------------------------------------------------
// mem_ctrl_rw_sched
// Read/write command scheduler between the AXI slave front-end and the LPDDR5
// command queue. Reads and writes are buffered in separate FIFOs; reads have
// priority, writes drain in bursts (high/low watermark, aging timer, run
// limit), and every direction change inserts TURN_CYCLES idle cycles.
// Ports:
//   clk_i, rst_n_i                   clock, asynchronous active-low reset
//   rd_req_valid/ready/cmd           read command input (ready = !rd_full)
//   wr_req_valid/ready/cmd           write command input (ready = !wr_full)
//   cmd_valid_o, cmd_data_o          registered scheduled command, bit 9 set
//                                    to the direction it was issued from
//   cmd_ready_i                      command queue can accept
//   rd_count_o, wr_count_o           FIFO occupancies
//   status_o                         {state, rd_full, wr_full, rd_empty,
//                                     wr_empty, cmd_valid_o, 1'b0}
// -----------------------------------------------------------------------------
module mem_ctrl_rw_sched
    import mem_ctrl_pkg::*;
#(
    parameter  int ID_WIDTH    = ID_WIDTH_DEF,
    parameter  int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter  int WR_HI_WM    = WR_HI_WM_DEF,
    parameter  int WR_LO_WM    = WR_LO_WM_DEF,
    parameter  int WR_MAX_WAIT = WR_MAX_WAIT_DEF,
    parameter  int MAX_WR_RUN  = MAX_WR_RUN_DEF,
    parameter  int TURN_CYCLES = TURN_CYCLES_DEF,
    localparam int CMD_BITS    = ID_WIDTH + ADDR_WIDTH + 10,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                rd_req_valid_i,
    output logic                rd_req_ready_o,
    input  logic [CMD_BITS-1:0] rd_req_cmd_i,
    input  logic                wr_req_valid_i,
    output logic                wr_req_ready_o,
    input  logic [CMD_BITS-1:0] wr_req_cmd_i,
    output logic                cmd_valid_o,
    output logic [CMD_BITS-1:0] cmd_data_o,
    input  logic                cmd_ready_i,
    output logic [CNT_W-1:0]    rd_count_o,
    output logic [CNT_W-1:0]    wr_count_o,
    output logic [7:0]          status_o
);

    localparam int RUN_W  = $clog2(MAX_WR_RUN + 1);
    localparam int TURN_W = $clog2(TURN_CYCLES + 1);

    localparam logic [CNT_W-1:0]  HI_WM     = CNT_W'(WR_HI_WM);
    localparam logic [CNT_W-1:0]  LO_WM     = CNT_W'(WR_LO_WM);
    localparam logic [7:0]        MAX_WAIT  = 8'(WR_MAX_WAIT);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_WR_RUN);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

    sched_state_e        r_state;
    sched_state_e        w_next_state;
    logic [TURN_W-1:0]   r_turn_cnt;
    logic [7:0]          r_wr_wait;
    logic [RUN_W-1:0]    r_wr_run;
    logic                r_cmd_valid;
    logic [CMD_BITS-1:0] r_cmd_data;

    logic [CMD_BITS-1:0] w_rd_head;
    logic [CMD_BITS-1:0] w_wr_head;
    logic [CMD_BITS-1:0] w_issue_cmd;
    logic [CNT_W-1:0]    w_rd_count;
    logic [CNT_W-1:0]    w_wr_count;
    logic                w_rd_full;
    logic                w_wr_full;
    logic                w_rd_empty;
    logic                w_wr_empty;
    logic                w_slot;
    logic                w_issue_rd;
    logic                w_issue_wr;

    mem_ctrl_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_BITS)) u_rd_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_push  (rd_req_valid_i),
        .i_data  (rd_req_cmd_i),
        .i_pop   (w_issue_rd),
        .o_data  (w_rd_head),
        .o_count (w_rd_count),
        .o_full  (w_rd_full),
        .o_empty (w_rd_empty)
    );

    mem_ctrl_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_BITS)) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_push  (wr_req_valid_i),
        .i_data  (wr_req_cmd_i),
        .i_pop   (w_issue_wr),
        .o_data  (w_wr_head),
        .o_count (w_wr_count),
        .o_full  (w_wr_full),
        .o_empty (w_wr_empty)
    );

    // The output register can take a new command when it is empty or is
    // being consumed this cycle.
    assign w_slot = !r_cmd_valid || cmd_ready_i;

    // Switch decisions take precedence over issue: a cycle that changes
    // direction never pops a FIFO.
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_issue_rd   = 1'b0;
        w_issue_wr   = 1'b0;
        unique case (r_state)
            S_READ: begin
                if ((w_wr_count >= HI_WM) || (w_rd_empty && !w_wr_empty) ||
                    (r_wr_wait == MAX_WAIT)) begin
                    w_next_state = S_TURN_R2W;
                end else if (!w_rd_empty && w_slot) begin
                    w_issue_rd = 1'b1;
                end
            end
            S_WRITE: begin
                if (!w_rd_empty && (w_wr_empty || (w_wr_count <= LO_WM) ||
                                    (r_wr_run == RUN_MAX))) begin
                    w_next_state = S_TURN_W2R;
                end else if (!w_wr_empty && w_slot) begin
                    w_issue_wr = 1'b1;
                end
            end
            S_TURN_R2W: if (r_turn_cnt == TURN_LAST) w_next_state = S_WRITE;
            S_TURN_W2R: if (r_turn_cnt == TURN_LAST) w_next_state = S_READ;
            default:    w_next_state = S_READ;
        endcase
    end

    // Direction bit of the issued command reflects the source FIFO, not the
    // bit presented by the front-end.
    always_comb begin
        w_issue_cmd             = w_issue_wr ? w_wr_head : w_rd_head;
        w_issue_cmd[CMD_WR_BIT] = w_issue_wr;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_READ;
            r_turn_cnt <= '0;
            r_wr_wait  <= '0;
            r_wr_run   <= '0;
        end else begin
            r_state <= w_next_state;

            // Turn counter runs only while parked in a turn state.
            if (((r_state == S_TURN_R2W) || (r_state == S_TURN_W2R)) &&
                (w_next_state == r_state)) begin
                r_turn_cnt <= r_turn_cnt + TURN_W'(1);
            end else begin
                r_turn_cnt <= '0;
            end

            // Age of the oldest pending write, measured only in read mode.
            if ((r_state == S_READ) && !w_wr_empty) begin
                if (r_wr_wait != 8'hFF) r_wr_wait <= r_wr_wait + 8'd1;
            end else begin
                r_wr_wait <= '0;
            end

            if ((r_state == S_TURN_R2W) && (w_next_state == S_WRITE)) begin
                r_wr_run <= '0;
            end else if (w_issue_wr && (r_wr_run != RUN_MAX)) begin
                r_wr_run <= r_wr_run + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
        end else if (w_issue_rd || w_issue_wr) begin
            r_cmd_valid <= 1'b1;
            r_cmd_data  <= w_issue_cmd;
        end else if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
        end
    end

    assign rd_req_ready_o = !w_rd_full;
    assign wr_req_ready_o = !w_wr_full;
    assign cmd_valid_o    = r_cmd_valid;
    assign cmd_data_o     = r_cmd_data;
    assign rd_count_o     = w_rd_count;
    assign wr_count_o     = w_wr_count;
    assign status_o       = {r_state, w_rd_full, w_wr_full, w_rd_empty,
                             w_wr_empty, r_cmd_valid, 1'b0};

endmodule

// File: tb/tb_mem_ctrl_rw_sched.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_rw_sched
// Directed bench for mem_ctrl_rw_sched. A queue-based reference model tracks
// both FIFOs, the scheduling mode and the output register from the
// scheduling rules; a compare process checks the DUT against it every cycle.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_rw_sched;
    import mem_ctrl_pkg::*;

    localparam int FIFO_DEPTH  = 8;
    localparam int WR_HI_WM    = 6;
    localparam int WR_LO_WM    = 2;
    localparam int WR_MAX_WAIT = 64;
    localparam int MAX_WR_RUN  = 16;
    localparam int TURN_CYCLES = 4;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    localparam int M_READ  = 0;
    localparam int M_WRITE = 1;
    localparam int M_R2W   = 2;
    localparam int M_W2R   = 3;

    logic             clk_i;
    logic             rst_n_i;
    logic             rd_req_valid_i;
    logic             rd_req_ready_o;
    logic [CMD_W-1:0] rd_req_cmd_i;
    logic             wr_req_valid_i;
    logic             wr_req_ready_o;
    logic [CMD_W-1:0] wr_req_cmd_i;
    logic             cmd_valid_o;
    logic [CMD_W-1:0] cmd_data_o;
    logic             cmd_ready_i;
    logic [CNT_W-1:0] rd_count_o;
    logic [CNT_W-1:0] wr_count_o;
    logic [7:0]       status_o;

    int n_tests;
    int n_fail;

    mem_ctrl_rw_sched #(
        .ID_WIDTH    (8),
        .ADDR_WIDTH  (40),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .WR_HI_WM    (WR_HI_WM),
        .WR_LO_WM    (WR_LO_WM),
        .WR_MAX_WAIT (WR_MAX_WAIT),
        .MAX_WR_RUN  (MAX_WR_RUN),
        .TURN_CYCLES (TURN_CYCLES)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rd_req_valid_i (rd_req_valid_i),
        .rd_req_ready_o (rd_req_ready_o),
        .rd_req_cmd_i   (rd_req_cmd_i),
        .wr_req_valid_i (wr_req_valid_i),
        .wr_req_ready_o (wr_req_ready_o),
        .wr_req_cmd_i   (wr_req_cmd_i),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_data_o     (cmd_data_o),
        .cmd_ready_i    (cmd_ready_i),
        .rd_count_o     (rd_count_o),
        .wr_count_o     (wr_count_o),
        .status_o       (status_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk(input logic [7:0] id, input logic [39:0] addr,
                                           input logic wr);
        logic [CMD_W-1:0] c;
        c = {id, addr, 10'b0};
        c[CMD_WR_BIT]      = wr;
        c[LEN_LSB +: 4]    = 4'h3;
        c[SIZE_LSB +: 3]   = 3'h2;
        c[BURST_LSB +: 2]  = 2'h1;
        return c;
    endfunction

    // ---------------------------------------------------------------- model
    logic [CMD_W-1:0] rq[$];
    logic [CMD_W-1:0] wq[$];
    int               m_mode;
    int               m_turn_left;
    int               m_wait;
    int               m_run;
    logic             m_valid;
    logic [CMD_W-1:0] m_data;

    initial begin
        m_mode = M_READ; m_turn_left = 0; m_wait = 0; m_run = 0;
        m_valid = 1'b0; m_data = '0;
        forever begin
            bit slot, acc_r, acc_w, iss_r, iss_w, aging;
            @(posedge clk_i or negedge rst_n_i);
            if (!rst_n_i) begin
                rq.delete(); wq.delete();
                m_mode = M_READ; m_turn_left = 0; m_wait = 0; m_run = 0;
                m_valid = 1'b0; m_data = '0;
            end else begin
                slot  = !m_valid || cmd_ready_i;
                acc_r = rd_req_valid_i && (rq.size() < FIFO_DEPTH);
                acc_w = wr_req_valid_i && (wq.size() < FIFO_DEPTH);
                aging = (m_mode == M_READ) && (wq.size() != 0);
                iss_r = 1'b0;
                iss_w = 1'b0;
                case (m_mode)
                    M_READ: begin
                        if (wq.size() >= WR_HI_WM || (rq.size() == 0 && wq.size() != 0) ||
                            m_wait == WR_MAX_WAIT) begin
                            m_mode = M_R2W; m_turn_left = TURN_CYCLES;
                        end else if (rq.size() != 0 && slot) iss_r = 1'b1;
                    end
                    M_WRITE: begin
                        if (rq.size() != 0 && (wq.size() <= WR_LO_WM || m_run == MAX_WR_RUN)) begin
                            m_mode = M_W2R; m_turn_left = TURN_CYCLES;
                        end else if (wq.size() != 0 && slot) iss_w = 1'b1;
                    end
                    default: begin
                        m_turn_left--;
                        if (m_turn_left == 0) begin
                            if (m_mode == M_R2W) begin m_mode = M_WRITE; m_run = 0; end
                            else m_mode = M_READ;
                        end
                    end
                endcase
                m_wait = aging ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
                if (iss_r) begin
                    m_data = rq.pop_front(); m_data[CMD_WR_BIT] = 1'b0; m_valid = 1'b1;
                end else if (iss_w) begin
                    m_data = wq.pop_front(); m_data[CMD_WR_BIT] = 1'b1; m_valid = 1'b1;
                    if (m_run < MAX_WR_RUN) m_run++;
                end else if (cmd_ready_i) begin
                    m_valid = 1'b0;
                end
                if (acc_r) rq.push_back(rd_req_cmd_i);
                if (acc_w) wq.push_back(wr_req_cmd_i);
            end
        end
    end

    // ------------------------------------------------------ compare process
    initial begin
        forever begin
            logic [7:0] exp_st;
            logic [1:0] mode2;
            @(negedge clk_i);
            mode2  = 2'(m_mode);
            exp_st = {mode2, rq.size() == FIFO_DEPTH, wq.size() == FIFO_DEPTH,
                      rq.size() == 0, wq.size() == 0, m_valid, 1'b0};
            check("cmd_valid", 64'(cmd_valid_o), 64'(m_valid));
            if (m_valid) check("cmd_data", 64'(cmd_data_o), 64'(m_data));
            check("rd_count", 64'(rd_count_o), 64'(rq.size()));
            check("wr_count", 64'(wr_count_o), 64'(wq.size()));
            check("status", 64'(status_o), 64'(exp_st));
            check("rd_ready", 64'(rd_req_ready_o), 64'(rq.size() < FIFO_DEPTH));
            check("wr_ready", 64'(wr_req_ready_o), 64'(wq.size() < FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic check_reset_values(input string tag);
        check({tag, "_valid"},  64'(cmd_valid_o),    64'd0);
        check({tag, "_data"},   64'(cmd_data_o),     64'd0);
        check({tag, "_rdcnt"},  64'(rd_count_o),     64'd0);
        check({tag, "_wrcnt"},  64'(wr_count_o),     64'd0);
        check({tag, "_rdrdy"},  64'(rd_req_ready_o), 64'd1);
        check({tag, "_wrrdy"},  64'(wr_req_ready_o), 64'd1);
        check({tag, "_status"}, 64'(status_o),       64'h0C);
    endtask

    task automatic do_reset();
        rd_req_valid_i = 1'b0;
        wr_req_valid_i = 1'b0;
        cmd_ready_i    = 1'b1;
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 check_reset_values("rst");
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
    endtask

    initial begin
        int n_wr;
        int n_xfer;
        int n_seen;
        n_tests = 0;
        n_fail  = 0;
        rst_n_i = 1'b0;
        rd_req_valid_i = 1'b0;
        wr_req_valid_i = 1'b0;
        rd_req_cmd_i   = '0;
        wr_req_cmd_i   = '0;
        cmd_ready_i    = 1'b1;

        // Single read: incoming bit 9 set, must be cleared on issue; N+2 latency.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            rd_req_valid_i = (i == 0);
            rd_req_cmd_i   = mk(8'h11, 40'h1000, 1'b1);
            if (i == 1) check("rd1_valid_n1", 64'(cmd_valid_o), 64'd0);
            if (i == 2) begin
                check("rd1_valid_n2", 64'(cmd_valid_o), 64'd1);
                check("rd1_data", 64'(cmd_data_o), 64'(mk(8'h11, 40'h1000, 1'b0)));
                check("rd1_mode", 64'(status_o[7:6]), 64'd0);
            end
            if (i == 3) check("rd1_valid_n3", 64'(cmd_valid_o), 64'd0);
        end

        // Lone write: 4-cycle turn, output at N+7 with bit 9 forced to 1.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            wr_req_valid_i = (i == 0);
            wr_req_cmd_i   = mk(8'h22, 40'h2200, 1'b0);
            if (i == 1) check("lw_mode_read", 64'(status_o[7:6]), 64'd0);
            if (i >= 2 && i <= 5) check("lw_mode_turn", 64'(status_o[7:6]), 64'd2);
            if (i == 6) begin
                check("lw_mode_write", 64'(status_o[7:6]), 64'd1);
                check("lw_valid_n6", 64'(cmd_valid_o), 64'd0);
            end
            if (i == 7) begin
                check("lw_valid_n7", 64'(cmd_valid_o), 64'd1);
                check("lw_data", 64'(cmd_data_o), 64'(mk(8'h22, 40'h2200, 1'b1)));
            end
            if (i == 12) check("lw_stay_write", 64'(status_o[7:6]), 64'd1);
        end

        // Watermark drain: continuous reads, 6 writes -> 4 writes, then reads.
        do_reset();
        n_wr = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk_i);
            rd_req_valid_i = (i < 30);
            rd_req_cmd_i   = mk(8'(8'h80 + i), 40'h10000 + 40'(i), 1'b0);
            wr_req_valid_i = (i >= 3 && i <= 8);
            wr_req_cmd_i   = mk(8'(8'h60 + i), 40'h20000 + 40'(i), 1'b1);
            if (i < 30 && cmd_valid_o && cmd_data_o[CMD_WR_BIT]) n_wr++;
            if (i == 10) check("wm_turn_r2w", 64'(status_o[7:6]), 64'd2);
            if (i == 14) check("wm_write", 64'(status_o[7:6]), 64'd1);
            if (i == 19) check("wm_turn_w2r", 64'(status_o[7:6]), 64'd3);
            if (i == 29) begin
                check("wm_wr_left", 64'(wr_count_o), 64'd2);
                check("wm_back_read", 64'(status_o[7:6]), 64'd0);
                check("wm_read_out", 64'({cmd_valid_o, cmd_data_o[CMD_WR_BIT]}), 64'b10);
            end
        end
        check("wm_writes_issued", 64'(n_wr), 64'd4);

        // Aging: one write waits under continuous reads until wr_wait hits 64.
        do_reset();
        for (int i = 0; i < 90; i++) begin
            @(negedge clk_i);
            rd_req_valid_i = (i < 85);
            rd_req_cmd_i   = mk(8'(i), 40'h30000 + 40'(i), 1'b0);
            wr_req_valid_i = (i == 2);
            wr_req_cmd_i   = mk(8'hE7, 40'h3E7E7, 1'b0);
            if (i == 67) begin
                check("age_still_read", 64'(status_o[7:6]), 64'd0);
                check("age_wr_pending", 64'(wr_count_o), 64'd1);
            end
            if (i == 68) check("age_turn", 64'(status_o[7:6]), 64'd2);
            if (i == 73) check("age_low_wm_back", 64'(status_o[7:6]), 64'd3);
        end

        // Backpressure: output held, FIFO fills to 8, no loss after release.
        do_reset();
        n_xfer = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk_i);
            cmd_ready_i    = (i >= 20);
            rd_req_valid_i = (i < 10);
            rd_req_cmd_i   = mk(8'(8'h40 + i), 40'h2000 + 40'(i), 1'b0);
            if (i >= 2 && i < 20) begin
                check("bp_hold_valid", 64'(cmd_valid_o), 64'd1);
                check("bp_hold_data", 64'(cmd_data_o), 64'(mk(8'h40, 40'h2000, 1'b0)));
            end
            if (i == 9) begin
                check("bp_rd_ready_full", 64'(rd_req_ready_o), 64'd0);
                check("bp_rd_count_full", 64'(rd_count_o), 64'd8);
            end
            if (i >= 20 && cmd_valid_o && cmd_ready_i) n_xfer++;
        end
        check("bp_transfers", 64'(n_xfer), 64'd9);

        // Reset mid-drain with 5 writes buffered; no stale command afterwards.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            wr_req_valid_i = (i < 5);
            wr_req_cmd_i   = mk(8'(8'hB0 + i), 40'h40000 + 40'(i), 1'b1);
            if (i == 6) begin
                check("mid_wr_count", 64'(wr_count_o), 64'd5);
                check("mid_mode", 64'(status_o[7:6]), 64'd1);
                #2 rst_n_i = 1'b0;
                #1 check_reset_values("mid_rst");
            end
        end
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        n_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            rd_req_valid_i = (i == 0);
            rd_req_cmd_i   = mk(8'hA5, 40'h5A5A5, 1'b0);
            if (cmd_valid_o) begin
                n_seen++;
                check("post_rst_cmd", 64'(cmd_data_o), 64'(mk(8'hA5, 40'h5A5A5, 1'b0)));
            end
            if (i == 2) check("post_rst_latency", 64'(cmd_valid_o), 64'd1);
        end
        check("post_rst_count", 64'(n_seen), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
